// File: rtl/vending_pkg.sv
// vending_pkg: coin codes and the pending-counter width, shared with the vending FSM
package vending_pkg;
    typedef logic [1:0] coin_t;
    localparam coin_t COIN_NONE = 2'b00;
    localparam coin_t COIN_5    = 2'b01;
    localparam coin_t COIN_10   = 2'b10;
    localparam int    PEND_W    = 3;
endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: synchronises and debounces one coin sensor, pulsing coin_event on each accepted rise
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic coin_event
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic          r_s1, r_s2, r_deb, r_deb_q;
    logic [CW-1:0] r_cnt;
    logic          w_hit;
    assign w_hit      = r_cnt == CW'(DEBOUNCE_CYCLES - 1);
    assign coin_event = r_deb & ~r_deb_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_q <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= raw;
            r_s2    <= r_s1;
            r_deb_q <= r_deb;
            if (r_s2 == r_deb) r_cnt <= '0;
            else if (w_hit) begin
                r_deb <= ~r_deb;
                r_cnt <= '0;
            end else r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: two debounced coin slots buffered and arbitrated into a one-coin-per-cycle code stream
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PEND_MAX        = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin5_raw,
    input  logic       coin10_raw,
    output logic [1:0] x,
    output logic       busy,
    output logic       coin_lost
);
    localparam logic [PEND_W-1:0] PMAX = PEND_W'(PEND_MAX);
    logic              w_ev5, w_ev10, w_c5, w_c10, w_g5, w_g10;
    logic              w_byp5, w_byp10, w_dec5, w_dec10, w_inc5, w_inc10, w_lost;
    logic [PEND_W-1:0] r_p5, r_p10, w_p5_next, w_p10_next;
    logic              r_last10;
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
        .clk(clk), .rst_n(rst_n), .raw(coin5_raw), .coin_event(w_ev5)
    );
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
        .clk(clk), .rst_n(rst_n), .raw(coin10_raw), .coin_event(w_ev10)
    );
    always_comb begin
        w_c5       = w_ev5 | (r_p5 != '0);
        w_c10      = w_ev10 | (r_p10 != '0);
        // on contention the slot that was not granted last wins
        w_g10      = w_c10 & (~w_c5 | ~r_last10);
        w_g5       = w_c5 & ~w_g10;
        // a grant drains the counter first, so an empty counter means the grant took the bypass event
        w_dec5     = w_g5 & (r_p5 != '0);
        w_dec10    = w_g10 & (r_p10 != '0);
        w_byp5     = w_g5 & (r_p5 == '0);
        w_byp10    = w_g10 & (r_p10 == '0);
        w_inc5     = w_ev5 & ~w_byp5 & ((r_p5 - PEND_W'(w_dec5)) < PMAX);
        w_inc10    = w_ev10 & ~w_byp10 & ((r_p10 - PEND_W'(w_dec10)) < PMAX);
        w_lost     = (w_ev5 & ~w_byp5 & ~w_inc5) | (w_ev10 & ~w_byp10 & ~w_inc10);
        w_p5_next  = r_p5 + PEND_W'(w_inc5) - PEND_W'(w_dec5);
        w_p10_next = r_p10 + PEND_W'(w_inc10) - PEND_W'(w_dec10);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p5      <= '0;
            r_p10     <= '0;
            r_last10  <= 1'b0;
            x         <= COIN_NONE;
            busy      <= 1'b0;
            coin_lost <= 1'b0;
        end else begin
            r_p5      <= w_p5_next;
            r_p10     <= w_p10_next;
            if (w_g5 | w_g10) r_last10 <= w_g10;
            x         <= w_g10 ? COIN_10 : w_g5 ? COIN_5 : COIN_NONE;
            busy      <= (w_p5_next != '0) | (w_p10_next != '0);
            coin_lost <= coin_lost | w_lost;
        end
    end
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: table-driven coin scenarios with a timed scoreboard, plus overflow and reset sequences
module tb_coin_acceptor;
    import vending_pkg::*;
    localparam int N = 4;
    typedef struct {
        logic       c5;
        logic       c10;
        int         bounces;
        logic [1:0] e0;
        logic [1:0] e1;
        logic       b0;
    } vec_t;
    typedef struct {
        logic [1:0] code;
        int         at;
        logic       busy;
    } exp_t;
    logic       clk = 1'b0, rst_n = 1'b0, coin5_raw = 1'b0, coin10_raw = 1'b0;
    logic [1:0] x, x1;
    logic       busy, busy1, coin_lost, coin_lost1;
    int         cyc = 0, n_vec = 0, n_err = 0;
    bit         mon_en = 1'b0;
    exp_t       sb[$];
    vec_t       tbl[8];
    logic [1:0] ox[6] = '{COIN_10, COIN_5, COIN_10, COIN_5, COIN_10, COIN_NONE};
    logic       ob[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       ol[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    coin_acceptor #(.DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw),
        .x(x), .busy(busy), .coin_lost(coin_lost)
    );
    coin_acceptor #(.DEBOUNCE_CYCLES(N), .PEND_MAX(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .coin5_raw(1'b0), .coin10_raw(1'b0),
        .x(x1), .busy(busy1), .coin_lost(coin_lost1)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at cyc %0d", name, got, exp, cyc);
        end
    endtask
    task automatic push(input logic [1:0] code, input int at, input logic b);
        exp_t e;
        e.code = code;
        e.at   = at;
        e.busy = b;
        sb.push_back(e);
    endtask
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (mon_en) begin
            if (x !== COIN_NONE) begin
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_code: got x=%b busy=%b at cyc %0d, expected no code", x, busy, cyc);
                end else begin
                    e = sb.pop_front();
                    n_vec++;
                    if (x !== e.code || busy !== e.busy || cyc != e.at) begin
                        n_err++;
                        $display("FAIL scoreboard: got x=%b busy=%b at cyc %0d, expected x=%b busy=%b at cyc %0d",
                                 x, busy, cyc, e.code, e.busy, e.at);
                    end
                end
            end else if (busy !== 1'b0) begin
                n_err++;
                $display("FAIL idle_busy: got busy=%b with x=00, expected 0 at cyc %0d", busy, cyc);
            end
        end
    endtask
    initial begin
        tbl[0] = '{1'b1, 1'b1, 0, COIN_10, COIN_5, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 0, COIN_5, COIN_NONE, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 3, COIN_10, COIN_NONE, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 0, COIN_5, COIN_10, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 2, COIN_5, COIN_10, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1, COIN_5, COIN_NONE, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 0, COIN_10, COIN_5, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 0, COIN_5, COIN_NONE, 1'b0};
        repeat (3) tick();
        check("reset_x", x, COIN_NONE);
        check("reset_busy", {1'b0, busy}, 2'b00);
        check("reset_lost", {1'b0, coin_lost}, 2'b00);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) tick();
        // overflow on the PEND_MAX=1 instance: three consecutive cycles of events on both slots
        force dut1.w_ev5 = 1'b1;
        force dut1.w_ev10 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("ovf_x", x1, ox[i]);
            check("ovf_busy", {1'b0, busy1}, {1'b0, ob[i]});
            check("ovf_lost", {1'b0, coin_lost1}, {1'b0, ol[i]});
            if (i == 2) begin
                release dut1.w_ev5;
                release dut1.w_ev10;
            end
        end
        for (int v = 0; v < 8; v++) begin
            for (int b = 0; b < tbl[v].bounces; b++) begin
                coin5_raw  = tbl[v].c5;
                coin10_raw = tbl[v].c10;
                repeat (N - 1) tick();
                coin5_raw  = 1'b0;
                coin10_raw = 1'b0;
                tick();
            end
            coin5_raw  = tbl[v].c5;
            coin10_raw = tbl[v].c10;
            push(tbl[v].e0, cyc + N + 3, tbl[v].b0);
            if (tbl[v].e1 != COIN_NONE) push(tbl[v].e1, cyc + N + 4, 1'b0);
            repeat (10) tick();
            coin5_raw  = 1'b0;
            coin10_raw = 1'b0;
            repeat (20) tick();
        end
        check("no_loss", {1'b0, coin_lost}, 2'b00);
        check("lost_sticky", {1'b0, coin_lost1}, 2'b01);
        // reset lands on the edge that would issue the pending 5 coin
        coin5_raw  = 1'b1;
        coin10_raw = 1'b1;
        push(COIN_10, cyc + N + 3, 1'b1);
        repeat (4) tick();
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_x", x, COIN_NONE);
        check("midrst_busy", {1'b0, busy}, 2'b00);
        check("midrst_lost", {1'b0, coin_lost}, 2'b00);
        check("midrst_lost1", {1'b0, coin_lost1}, 2'b00);
        rst_n = 1'b1;
        repeat (30) tick();
        coin10_raw = 1'b1;
        repeat (3) tick();
        coin10_raw = 1'b0;
        rst_n      = 1'b0;
        tick();
        rst_n = 1'b1;
        check("halfdeb_x", x, COIN_NONE);
        repeat (30) tick();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL missing_codes: got %0d codes never issued, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
